divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter WIDTH, default 16, operand/result bit width.
REQ-002 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 data_in  input  WIDTH  shared operand bus: dividend one cycle after start is accepted, divisor the cycle after that.
REQ-006 quotient  output  WIDTH  quotient register; valid only while done=1.
REQ-007 remainder  output  WIDTH  remainder register; valid only while done=1.
REQ-008 done  output  1  result valid; high throughout DONE state.
REQ-009 busy  output  1  high in LDA, LDB, CHK, SUB.
REQ-010 div_by_zero  output  1  error flag; valid only while done=1.

Function
REQ-011 Unsigned repeated-subtraction divider: quotient = dividend / divisor, remainder = dividend % divisor.
REQ-012 FSM states: IDLE, LDA, LDB, CHK, SUB, DONE; Moore outputs decoded from registered state.
REQ-013 IDLE: start=1 -> LDA; otherwise stay in IDLE.
REQ-014 LDA: remainder <= data_in, quotient <= 0, div_by_zero <= 0; -> LDB unconditionally.
REQ-015 LDB: divisor register <= data_in; -> CHK unconditionally.
REQ-016 CHK: divisor==0 -> DONE with div_by_zero <= 1, quotient <= all ones, remainder unchanged (= dividend); else -> SUB.
REQ-017 SUB: remainder >= divisor -> remainder <= remainder - divisor, quotient <= quotient + 1, stay in SUB; else -> DONE with no register update.
REQ-018 DONE: hold quotient, remainder, div_by_zero, done=1; start=1 -> LDA (done low next cycle); otherwise stay in DONE.
REQ-019 start in LDA, LDB, CHK, SUB is ignored; no abort, no queueing.
REQ-020 Latency: start sampled at edge k, done=1 after edge k+4+Q (Q = quotient), or after edge k+3 for divide-by-zero.
REQ-021 Comparison and subtraction are unsigned WIDTH-bit; quotient cannot overflow (Q <= dividend).
REQ-022 Boundary: dividend 0 -> Q=0, R=0; dividend < divisor -> Q=0, R=dividend; divisor 1 -> Q=dividend, R=0, worst case 2^WIDTH-1 SUB cycles.

Reset
REQ-023 rst=1 at a posedge -> state IDLE; quotient, remainder, divisor register 0; done, busy, div_by_zero 0.
REQ-024 rst takes priority over start and over any in-progress operation; a mid-SUB reset discards partial results.
REQ-025 After rst deasserts, the first start is accepted normally.

Structure
REQ-026 Shared package divider_pkg holds the state encoding constants (IDLE..DONE, 3-bit) and the default WIDTH.
REQ-027 Datapath (dividend/remainder, divisor and quotient registers, subtractor, >= comparator, zero detect) lives in sub-module div_datapath with load/dec-style control inputs.
REQ-028 divider holds the FSM and instantiates div_datapath; no combinational path from data_in to any output.

Verification
REQ-029 start at edge k, data_in=17 then 5 -> quotient=3, remainder=2, div_by_zero=0, done high after edge k+7.
REQ-030 data_in=5 then 17 -> quotient=0, remainder=5, done high after edge k+4.
REQ-031 data_in=9 then 0 -> div_by_zero=1, quotient=16'hFFFF, remainder=9, done high after edge k+3.
REQ-032 data_in=100 then 10, rst pulsed 1 cycle while in SUB -> all outputs 0, state IDLE next cycle; new start with 100/10 -> quotient=10, remainder=0.
REQ-033 In DONE after 17/5, start with 0 then 7 -> done low one cycle later, then quotient=0, remainder=0, done high after edge k+4.
REQ-034 start pulsed during SUB of 17/5 -> ignored; result still 3 rem 2 at unchanged latency.

Source files
------------

// File: rtl/divider_pkg.sv
// ============================================================================
// Module  : divider_pkg
// Purpose : Shared FSM state encoding and default operand width for divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package divider_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_CHK  = 3'd3,
    S_SUB  = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_datapath.sv
// ============================================================================
// Module  : div_datapath
// Purpose : Remainder/divisor/quotient registers with subtract, compare and
//           zero-detect, sequenced by load/dec strobes from the divider FSM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_datapath
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_a_i,
  input  logic             load_b_i,
  input  logic             dec_i,
  input  logic             set_dbz_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dbz_o,
  output logic             divisor_zero_o,
  output logic             rem_ge_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dbz_q, dbz_d;

  always_comb begin
    rem_d = rem_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    dbz_d = dbz_q;
    if (load_a_i) begin
      rem_d = data_i;
      quo_d = '0;
      dbz_d = 1'b0;
    end
    if (load_b_i) begin
      dvs_d = data_i;
    end
    // Divide-by-zero saturates the quotient and leaves the dividend in place.
    if (set_dbz_i) begin
      quo_d = '1;
      dbz_d = 1'b1;
    end
    if (dec_i) begin
      rem_d = rem_q - dvs_q;
      quo_d = quo_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient_o     = quo_q;
  assign remainder_o    = rem_q;
  assign dbz_o          = dbz_q;
  assign divisor_zero_o = (dvs_q == '0);
  assign rem_ge_o       = (rem_q >= dvs_q);

endmodule

`default_nettype wire

// File: rtl/divider.sv
// ============================================================================
// Module  : divider
// Purpose : Unsigned repeated-subtraction divider; FSM control around
//           div_datapath, operands delivered serially on data_in.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  state_e state_q;
  logic   w_divisor_zero;
  logic   w_rem_ge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_q <= S_LDA;
        S_LDA:   state_q <= S_LDB;
        S_LDB:   state_q <= S_CHK;
        S_CHK:   state_q <= w_divisor_zero ? S_DONE : S_SUB;
        S_SUB:   if (!w_rem_ge) state_q <= S_DONE;
        S_DONE:  if (start) state_q <= S_LDA;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Control strobes and status are pure decodes of the registered state.
  div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk           (clk),
    .rst           (rst),
    .load_a_i      (state_q == S_LDA),
    .load_b_i      (state_q == S_LDB),
    .dec_i         ((state_q == S_SUB) && w_rem_ge),
    .set_dbz_i     ((state_q == S_CHK) && w_divisor_zero),
    .data_i        (data_in),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .dbz_o         (div_by_zero),
    .divisor_zero_o(w_divisor_zero),
    .rem_ge_o      (w_rem_ge)
  );

  assign done = (state_q == S_DONE);
  assign busy = (state_q == S_LDA) || (state_q == S_LDB) ||
                (state_q == S_CHK) || (state_q == S_SUB);

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ============================================================================
// Module  : tb_divider
// Purpose : Self-checking bench for divider against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_divider;

  localparam int W     = 16;
  localparam int LIMIT = 5000;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
  logic         busy;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (done),
    .busy       (busy),
    .div_by_zero(div_by_zero)
  );

  // Reference: result and cycles from accepted start to done.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 3;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = 4 + int'(a / b);
    end
  endtask

  // Drives one transaction; lat = edges after the start edge until done (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int pulse_at,
                        output int lat, output logic done_k, output logic busy_k);
    @(negedge clk);
    start   = 1'b1;
    data_in = W'($urandom);
    @(posedge clk); #1;
    start   = 1'b0;
    data_in = a;
    done_k  = done;
    busy_k  = busy;
    @(posedge clk); #1;
    data_in = b;
    lat     = 1;
    while (done !== 1'b1 && lat < LIMIT) begin
      start = (lat == pulse_at);
      @(posedge clk); #1;
      lat++;
    end
    start   = 1'b0;
    data_in = W'($urandom);
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 5;
    if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [6] = '{16'd17, 16'd5, 16'd9, 16'd0, 16'd12, 16'd0};
    logic [W-1:0] tb [6] = '{16'd5, 16'd17, 16'd0, 16'd7, 16'd1, 16'd0};
    logic [W-1:0] eq, er;
    logic ez, dk, bk;
    int el, lat;
    for (int i = 0; i < 6; i++) begin
      model(ta[i], tb[i], eq, er, ez, el);
      run_op(ta[i], tb[i], -1, lat, dk, bk);
      n_checks += 6;
      if (lat != el) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el); end
      if (dk !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_after_start got=%b exp=0", i, dk); end
      if (bk !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy_after_start got=%b exp=1", i, bk); end
      if (quotient !== eq) begin n_fail++; $display("FAIL dir%0d_quotient got=%h exp=%h", i, quotient, eq); end
      if (remainder !== er) begin n_fail++; $display("FAIL dir%0d_remainder got=%h exp=%h", i, remainder, er); end
      if (div_by_zero !== ez) begin n_fail++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, div_by_zero, ez); end
    end
  endtask

  task automatic test_hold;
    int lat;
    logic dk, bk;
    run_op(16'd17, 16'd5, -1, lat, dk, bk);
    repeat (3) @(posedge clk);
    #1;
    n_checks += 4;
    if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done got=%b exp=1", done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy got=%b exp=0", busy); end
    if (quotient !== 16'd3) begin n_fail++; $display("FAIL hold_quotient got=%h exp=3", quotient); end
    if (remainder !== 16'd2) begin n_fail++; $display("FAIL hold_remainder got=%h exp=2", remainder); end
  endtask

  task automatic test_start_ignored;
    int lat;
    logic dk, bk;
    run_op(16'd17, 16'd5, 4, lat, dk, bk);
    n_checks += 3;
    if (lat != 7) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=7", lat); end
    if (quotient !== 16'd3) begin n_fail++; $display("FAIL ignore_quotient got=%h exp=3", quotient); end
    if (remainder !== 16'd2) begin n_fail++; $display("FAIL ignore_remainder got=%h exp=2", remainder); end
    // A restart must not be pending once the result is up.
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_no_restart done=%b exp=1", done); end
  endtask

  task automatic test_reset_mid_sub;
    int lat;
    logic dk, bk;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data_in = 16'd100;
    @(posedge clk); #1;
    data_in = 16'd10;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL midsub_busy busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks += 5;
    if (quotient !== '0) begin n_fail++; $display("FAIL midsub_rst_quotient got=%h exp=0", quotient); end
    if (remainder !== '0) begin n_fail++; $display("FAIL midsub_rst_remainder got=%h exp=0", remainder); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL midsub_rst_done got=%b exp=0", done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midsub_rst_busy got=%b exp=0", busy); end
    if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL midsub_rst_dbz got=%b exp=0", div_by_zero); end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midsub_idle busy=%b done=%b exp 0 0", busy, done);
    end
    run_op(16'd100, 16'd10, -1, lat, dk, bk);
    n_checks += 3;
    if (lat != 14) begin n_fail++; $display("FAIL midsub_rerun_latency got=%0d exp=14", lat); end
    if (quotient !== 16'd10) begin n_fail++; $display("FAIL midsub_rerun_quotient got=%h exp=a", quotient); end
    if (remainder !== 16'd0) begin n_fail++; $display("FAIL midsub_rerun_remainder got=%h exp=0", remainder); end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, eq, er;
    logic ez, dk, bk;
    int el, lat;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom_range(0, 2000));
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 4));
        2:       b = a + W'($urandom_range(0, 50));
        default: b = W'($urandom_range(1, 300));
      endcase
      model(a, b, eq, er, ez, el);
      run_op(a, b, -1, lat, dk, bk);
      n_checks += 4;
      if (lat != el) begin n_fail++; $display("FAIL rnd%0d_latency a=%0d b=%0d got=%0d exp=%0d", i, a, b, lat, el); end
      if (quotient !== eq) begin n_fail++; $display("FAIL rnd%0d_quotient a=%0d b=%0d got=%h exp=%h", i, a, b, quotient, eq); end
      if (remainder !== er) begin n_fail++; $display("FAIL rnd%0d_remainder a=%0d b=%0d got=%h exp=%h", i, a, b, remainder, er); end
      if (div_by_zero !== ez) begin n_fail++; $display("FAIL rnd%0d_dbz a=%0d b=%0d got=%b exp=%b", i, a, b, div_by_zero, ez); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0;
    test_reset();
    test_directed();
    test_hold();
    test_start_ignored();
    test_reset_mid_sub();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
